// File: rtl/csr_req_arbiter.sv
// csr_req_arbiter: round-robin sharing of one accelerator CSR port among NumReq requesters,
// with in-order read-response routing. Define CSR_ARB_ERR_EN for the sticky spurious-response flag.
module csr_req_arbiter #(
    parameter int NumReq         = 2,
    parameter int RegAddrWidth   = 3,
    parameter int RegDataWidth   = 32,
    parameter int MaxOutstanding = 4
) (
    input  logic                                 clk_i,
    input  logic                                 rst_i,
    input  logic [NumReq-1:0][RegAddrWidth-1:0]  req_addr_i,
    input  logic [NumReq-1:0][RegDataWidth-1:0]  req_wr_data_i,
    input  logic [NumReq-1:0]                    req_wr_en_i,
    input  logic [NumReq-1:0]                    req_valid_i,
    output logic [NumReq-1:0]                    req_ready_o,
    output logic [NumReq-1:0][RegDataWidth-1:0]  rsp_rd_data_o,
    output logic [NumReq-1:0]                    rsp_valid_o,
    input  logic [NumReq-1:0]                    rsp_ready_i,
    output logic [RegAddrWidth-1:0]              acc_addr_o,
    output logic [RegDataWidth-1:0]              acc_wr_data_o,
    output logic                                 acc_wr_en_o,
    output logic                                 acc_req_valid_o,
    input  logic                                 acc_req_ready_i,
    input  logic [RegDataWidth-1:0]              acc_rd_data_i,
    input  logic                                 acc_rsp_valid_i,
    output logic                                 acc_rsp_ready_o,
    output logic                                 err_o
);
    localparam int IdxW = (NumReq > 1) ? $clog2(NumReq) : 1;
    localparam int PtrW = $clog2(MaxOutstanding);
    localparam int CntW = PtrW + 1;

    // state | meaning: IDLE = arbitrate from rr_ptr | LOCKED = hold a stalled grant until handshake
    localparam logic [0:0] IDLE   = 1'b0;
    localparam logic [0:0] LOCKED = 1'b1;

    logic [0:0]      state_q;
    logic [IdxW-1:0] rr_ptr_q;
    logic [IdxW-1:0] lock_idx_q;
    logic [IdxW-1:0] id_mem_q [MaxOutstanding];
    logic [PtrW-1:0] wr_ptr_q;
    logic [PtrW-1:0] rd_ptr_q;
    logic [CntW-1:0] count_q;

    logic              full;
    logic              empty;
    logic [NumReq-1:0] eligible;
    logic [IdxW-1:0]   grant_idx;
    logic [IdxW-1:0]   grant_next;
    logic [IdxW-1:0]   head_idx;
    logic [IdxW-1:0]   cand;
    logic              fwd;
    logic              req_hs;
    logic              push;
    logic              pop;

    assign full  = (count_q == CntW'(MaxOutstanding));
    assign empty = (count_q == '0);

    // Reads are masked out of arbitration once the ID FIFO is full; writes always compete.
    always_comb begin
        eligible = '0;
        for (int i = 0; i < NumReq; i++) begin
            eligible[i] = req_valid_i[i] & (req_wr_en_i[i] | ~full);
        end
    end

    always_comb begin
        grant_idx = lock_idx_q;
        fwd       = 1'b0;
        cand      = '0;
        if (state_q == LOCKED) begin
            fwd = eligible[lock_idx_q];
        end else begin
            for (int k = NumReq - 1; k >= 0; k--) begin
                cand = IdxW'((int'(rr_ptr_q) + k) % NumReq);
                if (eligible[cand]) begin
                    grant_idx = cand;
                    fwd       = 1'b1;
                end
            end
        end
        if (rst_i) begin
            fwd = 1'b0;
        end
    end

    assign req_hs     = fwd & acc_req_ready_i;
    assign push       = req_hs & ~req_wr_en_i[grant_idx];
    assign head_idx   = id_mem_q[rd_ptr_q];
    assign pop        = acc_rsp_valid_i & ~empty & rsp_ready_i[head_idx];
    assign grant_next = (int'(grant_idx) == NumReq - 1) ? '0 : grant_idx + 1'b1;

    always_comb begin
        req_ready_o = '0;
        rsp_valid_o = '0;
        if (fwd) begin
            req_ready_o[grant_idx] = acc_req_ready_i;
        end
        if (!empty) begin
            rsp_valid_o[head_idx] = acc_rsp_valid_i;
        end
    end

    assign acc_req_valid_o = fwd;
    assign acc_addr_o      = fwd ? req_addr_i[grant_idx] : '0;
    assign acc_wr_data_o   = fwd ? req_wr_data_i[grant_idx] : '0;
    assign acc_wr_en_o     = fwd ? req_wr_en_i[grant_idx] : 1'b0;
    // With nothing outstanding, responses are drained so a stray one cannot wedge the port.
    assign acc_rsp_ready_o = empty ? 1'b1 : rsp_ready_i[head_idx];
    assign rsp_rd_data_o   = {NumReq{acc_rd_data_i}};

    always_ff @(posedge clk_i or posedge rst_i) begin
        if (rst_i) begin
            state_q    <= IDLE;
            rr_ptr_q   <= '0;
            lock_idx_q <= '0;
        end else if (req_hs) begin
            state_q  <= IDLE;
            rr_ptr_q <= grant_next;
        end else if (fwd && state_q == IDLE) begin
            state_q    <= LOCKED;
            lock_idx_q <= grant_idx;
        end
    end

    always_ff @(posedge clk_i or posedge rst_i) begin
        if (rst_i) begin
            wr_ptr_q <= '0;
            rd_ptr_q <= '0;
            count_q  <= '0;
        end else begin
            if (push) begin
                wr_ptr_q <= wr_ptr_q + 1'b1;
            end
            if (pop) begin
                rd_ptr_q <= rd_ptr_q + 1'b1;
            end
            if (push && !pop) begin
                count_q <= count_q + 1'b1;
            end else if (pop && !push) begin
                count_q <= count_q - 1'b1;
            end
        end
    end

    always_ff @(posedge clk_i) begin
        if (push) begin
            id_mem_q[wr_ptr_q] <= grant_idx;
        end
    end

`ifdef CSR_ARB_ERR_EN
    logic err_q;

    always_ff @(posedge clk_i or posedge rst_i) begin
        if (rst_i) begin
            err_q <= 1'b0;
        end else if (acc_rsp_valid_i && empty) begin
            err_q <= 1'b1;
        end
    end

    assign err_o = err_q;
`else
    assign err_o = 1'b0;
`endif

endmodule

// File: tb/tb_csr_req_arbiter.sv
// Scoreboard bench for csr_req_arbiter: directed scenarios followed by randomized traffic,
// checked against a queue-based reference model of the arbitration and response routing rules.
module tb_csr_req_arbiter;
    localparam int N  = 2;
    localparam int AW = 3;
    localparam int DW = 32;
    localparam int MO = 4;

`ifdef CSR_ARB_ERR_EN
    localparam bit ErrEn = 1'b1;
`else
    localparam bit ErrEn = 1'b0;
`endif

    logic                 clk = 1'b0;
    logic                 rst;
    logic [N-1:0][AW-1:0] req_addr;
    logic [N-1:0][DW-1:0] req_wdata;
    logic [N-1:0]         req_we;
    logic [N-1:0]         req_valid;
    logic [N-1:0]         req_ready;
    logic [N-1:0][DW-1:0] rsp_data;
    logic [N-1:0]         rsp_valid;
    logic [N-1:0]         rsp_ready;
    logic [AW-1:0]        acc_addr;
    logic [DW-1:0]        acc_wdata;
    logic                 acc_we;
    logic                 acc_req_valid;
    logic                 acc_req_ready;
    logic [DW-1:0]        acc_rdata;
    logic                 acc_rsp_valid;
    logic                 acc_rsp_ready;
    logic                 err;

    int checks = 0;
    int errors = 0;

    always #5 clk = ~clk;

    csr_req_arbiter #(
        .NumReq(N), .RegAddrWidth(AW), .RegDataWidth(DW), .MaxOutstanding(MO)
    ) dut (
        .clk_i(clk), .rst_i(rst),
        .req_addr_i(req_addr), .req_wr_data_i(req_wdata), .req_wr_en_i(req_we),
        .req_valid_i(req_valid), .req_ready_o(req_ready),
        .rsp_rd_data_o(rsp_data), .rsp_valid_o(rsp_valid), .rsp_ready_i(rsp_ready),
        .acc_addr_o(acc_addr), .acc_wr_data_o(acc_wdata), .acc_wr_en_o(acc_we),
        .acc_req_valid_o(acc_req_valid), .acc_req_ready_i(acc_req_ready),
        .acc_rd_data_i(acc_rdata), .acc_rsp_valid_i(acc_rsp_valid), .acc_rsp_ready_o(acc_rsp_ready),
        .err_o(err)
    );

    typedef struct {
        int            idx;
        logic [AW-1:0] addr;
        logic [DW-1:0] data;
        logic          we;
    } req_t;

    typedef struct {
        int            idx;
        logic [DW-1:0] data;
    } rsp_t;

    req_t req_exp[$];
    rsp_t rsp_exp[$];

    // Reference model state: round-robin start, stalled requester (-1 = none), outstanding read owners.
    int rr_m   = 0;
    int lock_m = -1;
    int oq[$];
    bit err_m  = 1'b0;
    logic [N-1:0] hs_prev = '0;

    task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got 0x%0h, expected 0x%0h", name, act, exp);
        end
    endtask

    function automatic bit elig(input int i, input bit full);
        return req_valid[i] && (req_we[i] || !full);
    endfunction

    task automatic model_step();
        bit full;
        int g;
        if (rst) begin
            rr_m   = 0;
            lock_m = -1;
            oq.delete();
            err_m  = 1'b0;
            return;
        end
        full = (oq.size() == MO);
        g    = -1;
        if (lock_m >= 0) begin
            if (elig(lock_m, full)) g = lock_m;
        end else begin
            for (int k = 0; k < N; k++) begin
                if (g < 0 && elig((rr_m + k) % N, full)) g = (rr_m + k) % N;
            end
        end
        if (acc_rsp_valid) begin
            if (oq.size() == 0) begin
                err_m = 1'b1;
            end else if (rsp_ready[oq[0]]) begin
                rsp_exp.push_back(rsp_t'{oq[0], acc_rdata});
                void'(oq.pop_front());
            end
        end
        if (g >= 0) begin
            if (acc_req_ready) begin
                req_exp.push_back(req_t'{g, req_addr[g], req_wdata[g], req_we[g]});
                if (!req_we[g]) oq.push_back(g);
                rr_m   = (g + 1) % N;
                lock_m = -1;
            end else begin
                lock_m = g;
            end
        end
    endtask

    always @(posedge clk) begin
        #2;
        model_step();
    end

    always @(negedge clk) begin
        int   idx;
        int   cnt;
        req_t r;
        rsp_t s;
        if (rst) begin
            chk("rst_acc_req_valid", acc_req_valid, 0);
            chk("rst_req_ready", req_ready, 0);
            chk("rst_rsp_valid", rsp_valid, 0);
        end else begin
            if (acc_req_valid && acc_req_ready) begin
                idx = -1;
                cnt = 0;
                for (int i = 0; i < N; i++) if (req_ready[i]) begin idx = i; cnt++; end
                chk("req_ready_onehot", cnt, 1);
                if (req_exp.size() == 0) begin
                    checks++;
                    errors++;
                    $display("FAIL req_unexpected: grant %0d addr 0x%0h, no request expected", idx, acc_addr);
                end else begin
                    r = req_exp.pop_front();
                    chk("req_idx", idx, r.idx);
                    chk("req_addr", acc_addr, r.addr);
                    chk("req_wdata", acc_wdata, r.data);
                    chk("req_we", acc_we, r.we);
                end
            end
            if (|(rsp_valid & rsp_ready)) begin
                idx = -1;
                cnt = 0;
                for (int i = 0; i < N; i++) if (rsp_valid[i]) begin idx = i; cnt++; end
                chk("rsp_valid_onehot", cnt, 1);
                chk("rsp_acc_ready", acc_rsp_ready, 1);
                if (rsp_exp.size() == 0) begin
                    checks++;
                    errors++;
                    $display("FAIL rsp_unexpected: requester %0d, no response expected", idx);
                end else begin
                    s = rsp_exp.pop_front();
                    chk("rsp_idx", idx, s.idx);
                    chk("rsp_data", rsp_data[idx], s.data);
                end
            end
        end
        hs_prev = req_valid & req_ready;
    end

    task automatic next_cycle();
        @(posedge clk);
        #1;
    endtask

    initial begin
        rst = 1'b1;
        req_valid = 2'b11;
        req_we = '0;
        req_addr = '0;
        req_wdata = '0;
        acc_req_ready = 1'b1;
        acc_rsp_valid = 1'b0;
        acc_rdata = '0;
        rsp_ready = '0;
        repeat (2) next_cycle();
        @(negedge clk);
        chk("reset_acc_req_valid", acc_req_valid, 0);
        chk("reset_err", err, 0);
        next_cycle();

        // Round-robin with both requesters reading continuously.
        rst = 1'b0;
        rsp_ready = 2'b11;
        for (int k = 0; k < 4; k++) begin
            req_addr[0] = AW'($urandom);
            req_addr[1] = AW'($urandom);
            @(negedge clk);
            chk("rr_grant", req_ready, (k % 2 == 0) ? 2'b01 : 2'b10);
            next_cycle();
        end
        req_valid = '0;
        acc_rsp_valid = 1'b1;
        for (int k = 0; k < 4; k++) begin
            acc_rdata = $urandom;
            @(negedge clk);
            chk("drain_rsp_valid", rsp_valid, (k % 2 == 0) ? 2'b01 : 2'b10);
            next_cycle();
        end
        acc_rsp_valid = 1'b0;

        // Stalled grant to requester 1 is held while requester 0 arrives.
        acc_req_ready = 1'b0;
        req_we = 2'b11;
        req_addr[1] = 3'd5;
        req_addr[0] = 3'd2;
        req_valid = 2'b10;
        for (int k = 0; k < 4; k++) begin
            if (k == 1) req_valid[0] = 1'b1;
            if (k == 3) acc_req_ready = 1'b1;
            @(negedge clk);
            chk("lock_addr", acc_addr, 5);
            next_cycle();
        end
        req_valid[1] = 1'b0;
        @(negedge clk);
        chk("after_lock_addr", acc_addr, 2);
        chk("after_lock_grant", req_ready, 2'b01);
        next_cycle();

        // Fill outstanding reads, then check read hold-off and write bypass.
        req_we = 2'b00;
        req_valid = 2'b01;
        for (int k = 0; k < 4; k++) begin
            req_addr[0] = AW'($urandom);
            next_cycle();
        end
        req_valid = 2'b11;
        req_we = 2'b10;
        @(negedge clk);
        chk("full_write_pass", acc_req_valid, 1);
        chk("full_write_we", acc_we, 1);
        chk("full_write_grant", req_ready, 2'b10);
        next_cycle();
        req_valid = 2'b01;
        acc_rsp_valid = 1'b1;
        rsp_ready = 2'b11;
        @(negedge clk);
        chk("full_read_held", acc_req_valid, 0);
        chk("full_read_ready", req_ready, 0);
        next_cycle();
        acc_rsp_valid = 1'b0;
        @(negedge clk);
        chk("freed_read_valid", acc_req_valid, 1);
        chk("freed_read_grant", req_ready, 2'b01);
        next_cycle();
        req_valid = '0;
        acc_rsp_valid = 1'b1;
        repeat (4) next_cycle();
        acc_rsp_valid = 1'b0;

        // In-order response routing with a stalled requester.
        req_we = 2'b00;
        req_valid = 2'b10;
        next_cycle();
        req_valid = 2'b01;
        next_cycle();
        req_valid = '0;
        acc_rsp_valid = 1'b1;
        acc_rdata = 32'hA5;
        rsp_ready = 2'b01;
        @(negedge clk);
        chk("stall_rsp_valid", rsp_valid, 2'b10);
        chk("stall_acc_rsp_ready", acc_rsp_ready, 0);
        chk("stall_rsp_data", rsp_data[1], 32'hA5);
        next_cycle();
        rsp_ready = 2'b11;
        @(negedge clk);
        chk("rsp1_valid", rsp_valid, 2'b10);
        chk("rsp1_acc_ready", acc_rsp_ready, 1);
        next_cycle();
        acc_rdata = 32'h5A;
        @(negedge clk);
        chk("rsp0_valid", rsp_valid, 2'b01);
        chk("rsp0_data", rsp_data[0], 32'h5A);
        next_cycle();

        // Spurious response with nothing outstanding.
        @(negedge clk);
        chk("spurious_acc_ready", acc_rsp_ready, 1);
        chk("spurious_rsp_valid", rsp_valid, 0);
        next_cycle();
        acc_rsp_valid = 1'b0;
        @(negedge clk);
        chk("spurious_err", err, ErrEn);
        next_cycle();

        // Reset while LOCKED with two reads outstanding.
        req_valid = 2'b01;
        next_cycle();
        req_valid = 2'b10;
        next_cycle();
        acc_req_ready = 1'b0;
        next_cycle();
        rst = 1'b1;
        req_valid = 2'b11;
        @(negedge clk);
        chk("mid_reset_err", err, 0);
        chk("mid_reset_acc_valid", acc_req_valid, 0);
        next_cycle();
        rst = 1'b0;
        req_we = 2'b11;
        acc_req_ready = 1'b1;
        @(negedge clk);
        chk("post_reset_grant", req_ready, 2'b01);
        next_cycle();
        req_valid = 2'b10;
        next_cycle();
        req_valid = '0;
        acc_rsp_valid = 1'b1;
        @(negedge clk);
        chk("post_reset_spurious_valid", rsp_valid, 0);
        chk("post_reset_spurious_ready", acc_rsp_ready, 1);
        next_cycle();
        acc_rsp_valid = 1'b0;

        // Randomized traffic; requests stay stable until accepted.
        for (int c = 0; c < 3000; c++) begin
            for (int i = 0; i < N; i++) begin
                if (!req_valid[i] || hs_prev[i]) begin
                    req_valid[i] = ($urandom_range(0, 2) != 0);
                    req_we[i]    = ($urandom_range(0, 3) == 0);
                    req_addr[i]  = AW'($urandom);
                    req_wdata[i] = $urandom;
                end
            end
            acc_req_ready = ($urandom_range(0, 3) != 0);
            rsp_ready     = N'($urandom);
            acc_rdata     = $urandom;
            acc_rsp_valid = (oq.size() > 0) ? ($urandom_range(0, 2) != 0) : ($urandom_range(0, 63) == 0);
            next_cycle();
        end

        req_valid = '0;
        rsp_ready = '1;
        for (int c = 0; c < 20; c++) begin
            acc_rsp_valid = (oq.size() > 0);
            acc_rdata = $urandom;
            next_cycle();
        end
        acc_rsp_valid = 1'b0;
        next_cycle();
        chk("req_exp_drained", req_exp.size(), 0);
        chk("rsp_exp_drained", rsp_exp.size(), 0);
        chk("final_err", err, ErrEn && err_m);

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
